alarma_vehiculo_temporizada: RTL and testbench
==============================================

// Module: alarma_vehiculo_temporizada
// PURPOSE
//  Sequential, parametrised successor of the combinational car alarm (sLuz/sPrta/sIgn -> sAlr).
//  - Debounces every input.
//  - Supports N door channels.
//  - Applies a grace delay before alarming, then pulses the alarm output.
//  - Accepts a silence/acknowledge input.
//  Sits between raw cabin switches and the buzzer driver.
// PARAMETERS
//  N_PUERTAS   4  number of door switch channels (>=1)
//  DEB_CICLOS  4  consecutive cycles a raw input must differ from its filtered value to be accepted (>=1)
//  T_ESPERA    8  grace cycles from ESPERA entry to ALARMA entry (>=1)
//  T_PULSO     2  cycles per half-period of the sAlr on/off pattern (>=1)
// PORTS
//  clk              in   1          single clock, all state on rising edge
//  reset            in   1          asynchronous, active-high; clears all state immediately
//  sLuz             in   1          raw headlight switch (1 = on)
//  sPrta            in   N_PUERTAS  raw door switches (bit i = 1 -> door i open)
//  sIgn             in   1          raw ignition (1 = on)
//  sAck             in   1          silence request, synchronous clean level, not filtered
//  sAlr             out  1          registered buzzer output
//  sCond            out  1          alarm condition from filtered inputs
//  sPuerta_abierta  out  N_PUERTAS  filtered door state
//  estado           out  2          FSM state: 00 REPOSO, 01 ESPERA, 10 ALARMA, 11 SILENCIADO
// BEHAVIOUR
//  Reset values: sAlr=0, sPuerta_abierta=0, estado=00, sCond=0.
//   Reset also clears all filtered values, debounce counters and timers.
//  Debounce (independent per input: sLuz, sIgn, each sPrta bit)
//  - Counter increments on each edge where raw != filtered.
//  - Counter clears on any edge where raw == filtered.
//  - On the DEB_CICLOS-th consecutive differing edge: filtered <= raw, counter <= 0.
//  - A pulse shorter than DEB_CICLOS cycles never reaches the filtered value.
//  sCond = fLuz & ~fIgn & |fPrta. Combinational from filtered registers; no added latency.
//  FSM transitions. Priority inside each state: ~sCond > sAck > timer.
//  - REPOSO:     sCond -> ESPERA; timer <= T_ESPERA-1.
//  - ESPERA:     ~sCond -> REPOSO; sAck -> SILENCIADO;
//                timer==0 -> ALARMA; otherwise timer--.
//  - ALARMA:     ~sCond -> REPOSO; sAck -> SILENCIADO; otherwise stay.
//  - SILENCIADO: ~sCond -> REPOSO; otherwise stay (sAck ignored).
//  sAlr
//  - 0 in every state except ALARMA.
//  - Goes to 1 on the same edge estado becomes 10.
//  - Then holds for T_PULSO cycles, toggles every T_PULSO cycles.
//  - Drops to 0 on the same edge ALARMA is left.
//  - The pattern counter restarts on every ALARMA entry.
//  Latency: raw inputs satisfying the condition and held stable:
//   sCond after DEB_CICLOS edges; ESPERA 1 edge later; ALARMA T_ESPERA edges after that.
//  Boundary cases
//  - Re-entering REPOSO discards the remaining grace time; the next ESPERA reloads the full T_ESPERA.
//  - Ignition on, light off, or all doors closed has the same effect as ~sCond.
//  - Door set changing (one closes, another opens) with |fPrta staying 1 does not restart the timer.
//  - sAck and ~sCond on the same edge -> REPOSO.
//  - Reset asserted mid-operation forces all outputs to their reset values without a clock edge.
//  - After reset release, debouncing starts from filtered = 0.
// TESTING
//  1 Reset with raw inputs all 1 -> all outputs 0; after release, sIgn=1 keeps sCond=0 and estado=00 forever.
//  2 sLuz=1, sPrta=4'b0100, sIgn=0 from edge 0, defaults:
//     sCond=1 at edge 4, estado=01 at edge 5, estado=10 and sAlr=1 at edge 13;
//     sAlr pattern 1,1,0,0,1,1...
//  3 sPrta[0] glitch high for 3 cycles, sLuz=1, sIgn=0 -> sPuerta_abierta stays 0, estado stays 00, sAlr stays 0.
//  4 In ALARMA, sAck=1 for 1 cycle -> next edge estado=11, sAlr=0.
//     Then close the door: sCond=0 after 4 edges, estado=00 on the following edge.
//  5 In ESPERA at timer=3, sIgn=1 -> estado=00 four edges later, sAlr never 1.
//     Re-trigger -> full 8-cycle grace again.
//  6 reset asserted between edges while sAlr=1 in ALARMA -> sAlr=0 and estado=00 immediately.
//     With inputs held after release -> ALARMA again 13 edges after release.

Source files
------------

// File: rtl/alarma_vehiculo_temporizada.sv
// -----------------------------------------------------------------------------
// alarma_vehiculo_temporizada
//
// Timed car alarm. It sits between the raw cabin switches and the buzzer
// driver. Each raw input is debounced. The filtered values form the alarm
// condition (headlights on, ignition off, at least one door open). A grace
// period runs first, then the buzzer is pulsed. A silence request mutes the
// buzzer until the condition clears.
//
// Parameters
//   N_PUERTAS   number of door switch channels (>=1)
//   DEB_CICLOS  consecutive differing cycles needed to accept a raw change (>=1)
//   T_ESPERA    grace cycles from ESPERA entry to ALARMA entry (>=1)
//   T_PULSO     cycles per half-period of the buzzer on/off pattern (>=1)
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-high; clears all state
//   sLuz             in   raw headlight switch (1 = on)
//   sPrta            in   raw door switches (bit i = 1 -> door i open)
//   sIgn             in   raw ignition (1 = on)
//   sAck             in   silence request, clean synchronous level
//   sAlr             out  registered buzzer output
//   sCond            out  alarm condition from the filtered inputs
//   sPuerta_abierta  out  filtered door state
//   estado           out  FSM state: 00 REPOSO, 01 ESPERA, 10 ALARMA,
//                         11 SILENCIADO
// -----------------------------------------------------------------------------
module alarma_vehiculo_temporizada #(
    parameter int N_PUERTAS  = 4,
    parameter int DEB_CICLOS = 4,
    parameter int T_ESPERA   = 8,
    parameter int T_PULSO    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sLuz,
    input  logic [N_PUERTAS-1:0] sPrta,
    input  logic                 sIgn,
    input  logic                 sAck,
    output logic                 sAlr,
    output logic                 sCond,
    output logic [N_PUERTAS-1:0] sPuerta_abierta,
    output logic [1:0]           estado
);

    typedef enum logic [1:0] {
        REPOSO     = 2'b00,
        ESPERA     = 2'b01,
        ALARMA     = 2'b10,
        SILENCIADO = 2'b11
    } estado_t;

    // Debounced channels: doors in the low bits, then headlight, then ignition.
    localparam int N_CANALES = N_PUERTAS + 2;
    localparam int DEB_W     = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam int TIM_W     = (T_ESPERA   > 1) ? $clog2(T_ESPERA)   : 1;
    localparam int PUL_W     = (T_PULSO    > 1) ? $clog2(T_PULSO)    : 1;

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CICLOS - 1);
    localparam logic [TIM_W-1:0] TIM_MAX = TIM_W'(T_ESPERA - 1);
    localparam logic [PUL_W-1:0] PUL_MAX = PUL_W'(T_PULSO - 1);

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [N_CANALES-1:0] crudo;
    logic [N_CANALES-1:0] filtrado;
    logic [DEB_W-1:0]     cuenta [N_CANALES];

    assign crudo = {sIgn, sLuz, sPrta};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filtrado <= '0;
            // NOTE: the counter array is a bank of flops, not a RAM, so it
            // can and must be cleared by reset like any other register.
            for (int i = 0; i < N_CANALES; i++) begin
                cuenta[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CANALES; i++) begin
                if (crudo[i] != filtrado[i]) begin
                    // The DEB_CICLOS-th consecutive differing edge accepts
                    // the raw value.
                    if (cuenta[i] == DEB_MAX) begin
                        filtrado[i] <= crudo[i];
                        cuenta[i]   <= '0;
                    end else begin
                        cuenta[i] <= cuenta[i] + DEB_W'(1);
                    end
                end else begin
                    cuenta[i] <= '0;
                end
            end
        end
    end

    logic [N_PUERTAS-1:0] fPrta;
    logic                 fLuz;
    logic                 fIgn;

    assign fPrta = filtrado[N_PUERTAS-1:0];
    assign fLuz  = filtrado[N_PUERTAS];
    assign fIgn  = filtrado[N_PUERTAS+1];

    assign sCond           = fLuz & ~fIgn & (|fPrta);
    assign sPuerta_abierta = fPrta;

    // ------------------------------------------------------------------
    // FSM, grace timer and buzzer pattern
    // ------------------------------------------------------------------
    estado_t          estadoAct, estadoSig;
    logic [TIM_W-1:0] timer, timerSig;
    logic [PUL_W-1:0] pulso, pulsoSig;
    logic             sAlrSig;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        estadoSig = estadoAct;
        timerSig  = timer;
        pulsoSig  = pulso;
        sAlrSig   = 1'b0;

        // In each state the priority is: condition lost, then silence
        // request, then the timer.
        unique case (estadoAct)
            REPOSO: begin
                if (sCond) begin
                    estadoSig = ESPERA;
                    timerSig  = TIM_MAX;
                end
            end
            ESPERA: begin
                if (!sCond) begin
                    estadoSig = REPOSO;
                end else if (sAck) begin
                    estadoSig = SILENCIADO;
                end else if (timer == '0) begin
                    // Buzzer turns on on the same edge ALARMA is entered, and
                    // the pattern counter restarts on every entry.
                    estadoSig = ALARMA;
                    sAlrSig   = 1'b1;
                    pulsoSig  = '0;
                end else begin
                    timerSig = timer - TIM_W'(1);
                end
            end
            ALARMA: begin
                if (!sCond) begin
                    estadoSig = REPOSO;
                end else if (sAck) begin
                    estadoSig = SILENCIADO;
                end else if (pulso == PUL_MAX) begin
                    sAlrSig  = ~sAlr;
                    pulsoSig = '0;
                end else begin
                    sAlrSig  = sAlr;
                    pulsoSig = pulso + PUL_W'(1);
                end
            end
            SILENCIADO: begin
                if (!sCond) begin
                    estadoSig = REPOSO;
                end
            end
            default: estadoSig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estadoAct <= REPOSO;
            timer     <= '0;
            pulso     <= '0;
            sAlr      <= 1'b0;
        end else begin
            estadoAct <= estadoSig;
            timer     <= timerSig;
            pulso     <= pulsoSig;
            sAlr      <= sAlrSig;
        end
    end

    assign estado = estadoAct;

endmodule

// File: tb/tb_alarma_vehiculo_temporizada.sv
// -----------------------------------------------------------------------------
// tb_alarma_vehiculo_temporizada
//
// Directed testbench for alarma_vehiculo_temporizada with default parameters
// (4 doors, 4-cycle debounce, 8-cycle grace, 2-cycle half-period).
// Edge numbering: inputs are applied 1 time unit after a rising edge. The next
// rising edge is edge 1. Outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_alarma_vehiculo_temporizada;

    logic       clk;
    logic       reset;
    logic       sLuz;
    logic [3:0] sPrta;
    logic       sIgn;
    logic       sAck;
    logic       sAlr;
    logic       sCond;
    logic [3:0] sPuerta_abierta;
    logic [1:0] estado;

    int vecs = 0;
    int errs = 0;

    alarma_vehiculo_temporizada #(
        .N_PUERTAS (4),
        .DEB_CICLOS(4),
        .T_ESPERA  (8),
        .T_PULSO   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sLuz           (sLuz),
        .sPrta          (sPrta),
        .sIgn           (sIgn),
        .sAck           (sAck),
        .sAlr           (sAlr),
        .sCond          (sCond),
        .sPuerta_abierta(sPuerta_abierta),
        .estado         (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with all inputs idle, released 1 unit after an edge.
    task automatic apply_reset();
        reset = 1'b1;
        sLuz  = 1'b0;
        sPrta = 4'b0000;
        sIgn  = 1'b0;
        sAck  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // 1: reset with all raw inputs high; ignition keeps the alarm idle.
    task automatic test_reset();
        logic [7:0] obs, exp;
        reset = 1'b1;
        sLuz  = 1'b1;
        sPrta = 4'b1111;
        sIgn  = 1'b1;
        sAck  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs = {estado, sAlr, sCond, sPuerta_abierta};
        vecs++;
        if (obs !== 8'h00) begin
            errs++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 8'h00);
        end
        reset = 1'b0;
        sAck  = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp = {2'b00, 1'b0, 1'b0, (e >= 4) ? 4'b1111 : 4'b0000};
            obs = {estado, sAlr, sCond, sPuerta_abierta};
            vecs++;
            if (obs !== exp) begin
                errs++;
                $display("FAIL ign_on_idle edge %0d: got %b expected %b", e, obs, exp);
            end
        end
    endtask

    // 2: full latency path and buzzer pattern 1,1,0,0,1,1.
    task automatic test_latency();
        logic [7:0] obs, exp;
        logic [5:0] patron;
        logic [1:0] expEst;
        logic       expAlr;
        patron = 6'b110011;
        apply_reset();
        sLuz  = 1'b1;
        sPrta = 4'b0100;
        sIgn  = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            tick();
            expEst = (e < 5) ? 2'b00 : ((e < 13) ? 2'b01 : 2'b10);
            expAlr = (e >= 13) ? patron[5 - (e - 13)] : 1'b0;
            exp = {expEst, expAlr, (e >= 4), (e >= 4) ? 4'b0100 : 4'b0000};
            obs = {estado, sAlr, sCond, sPuerta_abierta};
            vecs++;
            if (obs !== exp) begin
                errs++;
                $display("FAIL latency edge %0d: got %b expected %b", e, obs, exp);
            end
        end
    endtask

    // 3: 3-cycle door glitch is rejected.
    task automatic test_glitch();
        logic [7:0] obs;
        apply_reset();
        sLuz  = 1'b1;
        sIgn  = 1'b0;
        sPrta = 4'b0001;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 3) sPrta = 4'b0000;
            obs = {estado, sAlr, sCond, sPuerta_abierta};
            vecs++;
            if (obs !== 8'h00) begin
                errs++;
                $display("FAIL glitch edge %0d: got %b expected %b", e, obs, 8'h00);
            end
        end
    endtask

    // 4: silence in ALARMA, sAck ignored in SILENCIADO, then door closes.
    task automatic test_ack();
        logic [3:0] obs, exp;
        apply_reset();
        sLuz  = 1'b1;
        sPrta = 4'b0100;
        sIgn  = 1'b0;
        repeat (13) tick();
        obs = {estado, sAlr, sCond};
        vecs++;
        if (obs !== 4'b1011) begin
            errs++;
            $display("FAIL ack_in_alarm: got %b expected %b", obs, 4'b1011);
        end
        sAck = 1'b1;
        tick();
        sAck = 1'b0;
        obs = {estado, sAlr, sCond};
        vecs++;
        if (obs !== 4'b1101) begin
            errs++;
            $display("FAIL ack_silence: got %b expected %b", obs, 4'b1101);
        end
        sAck = 1'b1;
        repeat (2) tick();
        sAck = 1'b0;
        obs = {estado, sAlr, sCond};
        vecs++;
        if (obs !== 4'b1101) begin
            errs++;
            $display("FAIL ack_ignored: got %b expected %b", obs, 4'b1101);
        end
        sPrta = 4'b0000;
        for (int e = 1; e <= 5; e++) begin
            tick();
            exp = {(e < 5) ? 2'b11 : 2'b00, 1'b0, (e < 4)};
            obs = {estado, sAlr, sCond};
            vecs++;
            if (obs !== exp) begin
                errs++;
                $display("FAIL ack_close edge %0d: got %b expected %b", e, obs, exp);
            end
        end
    endtask

    // 5: ignition raised while the grace timer is being loaded with 3 (sIgn is
    // applied just before that edge), so the abort lands before the timer
    // expires. A re-trigger then gets the full grace period again.
    task automatic test_abort();
        logic [3:0] obs, exp;
        apply_reset();
        sLuz  = 1'b1;
        sPrta = 4'b0100;
        sIgn  = 1'b0;
        repeat (8) tick();
        sIgn = 1'b1;
        for (int e = 9; e <= 13; e++) begin
            tick();
            exp = {(e < 13) ? 2'b01 : 2'b00, 1'b0, (e < 12)};
            obs = {estado, sAlr, sCond};
            vecs++;
            if (obs !== exp) begin
                errs++;
                $display("FAIL abort edge %0d: got %b expected %b", e, obs, exp);
            end
        end
        sIgn = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp = {(e < 5) ? 2'b00 : ((e < 13) ? 2'b01 : 2'b10), (e == 13), (e >= 4)};
            obs = {estado, sAlr, sCond};
            vecs++;
            if (obs !== exp) begin
                errs++;
                $display("FAIL retrigger edge %0d: got %b expected %b", e, obs, exp);
            end
        end
    endtask

    // Door set changes during ESPERA without |doors dropping: no timer restart.
    task automatic test_door_swap();
        logic [7:0] obs, exp;
        apply_reset();
        sLuz  = 1'b1;
        sPrta = 4'b0100;
        sIgn  = 1'b0;
        repeat (6) tick();
        sPrta = 4'b0010;
        for (int e = 7; e <= 13; e++) begin
            tick();
            exp = {(e < 13) ? 2'b01 : 2'b10, (e == 13), 1'b1,
                   (e < 10) ? 4'b0100 : 4'b0010};
            obs = {estado, sAlr, sCond, sPuerta_abierta};
            vecs++;
            if (obs !== exp) begin
                errs++;
                $display("FAIL door_swap edge %0d: got %b expected %b", e, obs, exp);
            end
        end
    endtask

    // 6: asynchronous reset in ALARMA, then recovery with held inputs.
    task automatic test_reset_mid();
        logic [7:0] obs;
        logic [3:0] obs4, exp4;
        apply_reset();
        sLuz  = 1'b1;
        sPrta = 4'b0100;
        sIgn  = 1'b0;
        repeat (13) tick();
        obs4 = {estado, sAlr, sCond};
        vecs++;
        if (obs4 !== 4'b1011) begin
            errs++;
            $display("FAIL mid_pre_reset: got %b expected %b", obs4, 4'b1011);
        end
        #2;
        reset = 1'b1;
        #1;
        obs = {estado, sAlr, sCond, sPuerta_abierta};
        vecs++;
        if (obs !== 8'h00) begin
            errs++;
            $display("FAIL mid_async_reset: got %b expected %b", obs, 8'h00);
        end
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp4 = {(e < 5) ? 2'b00 : ((e < 13) ? 2'b01 : 2'b10), (e == 13), (e >= 4)};
            obs4 = {estado, sAlr, sCond};
            vecs++;
            if (obs4 !== exp4) begin
                errs++;
                $display("FAIL mid_recover edge %0d: got %b expected %b", e, obs4, exp4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_ack();
        test_abort();
        test_door_swap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
